// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-bit shift-register serial link (transmitter and
// receiver sides): FSM state encoding, default word width and parity sense.
package serial_link_pkg;

  localparam int   DEFAULT_WIDTH = 4;
  localparam logic EVEN_PARITY   = 1'b0;  // XOR of data and parity bit must equal this

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } link_state_t;

endpackage

// File: rtl/serial_word_rx_if.sv
// Bus between the serial word receiver and its surroundings.
//   si, si_valid, clear, q_ready : toward the receiver
//   Q, q_valid, busy, bit_cnt, overrun, parity_err : from the receiver
// master = stimulus/consumer side, slave = receiver.
interface serial_word_rx_if
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             si;
  logic             si_valid;
  logic             clear;
  logic [WIDTH-1:0] Q;
  logic             q_valid;
  logic             q_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             parity_err;

  modport master (
    output si, si_valid, clear, q_ready,
    input  Q, q_valid, busy, bit_cnt, overrun, parity_err
  );

  modport slave (
    input  si, si_valid, clear, q_ready,
    output Q, q_valid, busy, bit_cnt, overrun, parity_err
  );

endinterface

// File: rtl/serial_word_rx_out_buffer.sv
// serial_out_buffer: holding register for a completed word.
//   load_en/load_data : a word completed this edge
//   q_ready           : consumer accepts q when q_valid is also high
//   clear             : drops the sticky overrun flag (q/q_valid untouched)
//   q, q_valid        : held word and its valid flag
//   overrun           : sticky, a completed word arrived while q was unconsumed
module serial_out_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             overrun
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load_en) begin
        // Empty slot, or slot being drained on this same edge: take the word.
        if (!q_valid || q_ready) begin
          q       <= load_data;
          q_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
      // load_en is never raised together with clear, so this cannot race a set.
      if (clear) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: LSB-first deserializer with a double-buffered output.
// Ports: clock, reset (async, active-high), bus (serial_word_rx_if.slave).
// Build option: SERIAL_WORD_RX_PARITY_CHECK_EN adds a trailing even-parity bit
// per word; failing words are discarded with a one-cycle parity_err pulse.
module serial_word_rx
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_word_rx_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  link_state_t      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, shifted, load_word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_en;
  logic [WIDTH-1:0] q_w;
  logic             q_valid_w, overrun_w;

  // Transmitter shifts right, so each new bit enters at the MSB.
  assign shifted = {bus.si, sr_q[WIDTH-1:1]};

`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  logic perr_q, perr_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    load_en   = 1'b0;
    load_word = sr_q;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
    perr_d    = 1'b0;
`endif
    if (bus.clear) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.si_valid) begin
          sr_d    = shifted;
          cnt_d   = CNT_W'(1);
          state_d = DATA;
        end
        DATA: if (bus.si_valid) begin
          sr_d = shifted;
          if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
            cnt_d   = CNT_W'(WIDTH);
            state_d = PAR;
`else
            // Hand the fully shifted word over on the same edge.
            load_en   = 1'b1;
            load_word = shifted;
            cnt_d     = '0;
            state_d   = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
        PAR: if (bus.si_valid) begin
          if ((^{sr_q, bus.si}) == EVEN_PARITY) load_en = 1'b1;
          else                                   perr_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  serial_out_buffer #(.WIDTH(WIDTH)) u_out_buf (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.clear),
    .load_en   (load_en),
    .load_data (load_word),
    .q_ready   (bus.q_ready),
    .q         (q_w),
    .q_valid   (q_valid_w),
    .overrun   (overrun_w)
  );

  assign bus.Q       = q_w;
  assign bus.q_valid = q_valid_w;
  assign bus.overrun = overrun_w;
  assign bus.busy    = (state_q != IDLE);
  assign bus.bit_cnt = cnt_q;
`ifdef SERIAL_WORD_RX_PARITY_CHECK_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
